// File: rtl/four_bit_counter_pkg.sv
// Shared state encoding and helpers for the 16-state up-counter FSM.
`timescale 1ns/1ps
package four_bit_counter_pkg;

    localparam int unsigned STATE_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S0  = 4'd0;
    localparam state_t S1  = 4'd1;
    localparam state_t S2  = 4'd2;
    localparam state_t S3  = 4'd3;
    localparam state_t S4  = 4'd4;
    localparam state_t S5  = 4'd5;
    localparam state_t S6  = 4'd6;
    localparam state_t S7  = 4'd7;
    localparam state_t S8  = 4'd8;
    localparam state_t S9  = 4'd9;
    localparam state_t S10 = 4'd10;
    localparam state_t S11 = 4'd11;
    localparam state_t S12 = 4'd12;
    localparam state_t S13 = 4'd13;
    localparam state_t S14 = 4'd14;
    localparam state_t S15 = 4'd15;

    // Advance only on a clean 1; an unknown enable falls through to hold.
    function automatic state_t step_sel(input logic en, input state_t hold_s, input state_t adv_s);
        if (en == 1'b1) begin
            return adv_s;
        end
        return hold_s;
    endfunction

endpackage

// File: rtl/four_bit_counter_next.sv
// Next-state decode for the counter FSM: one case arm per count value.
`timescale 1ns/1ps
module four_bit_counter_next
    import four_bit_counter_pkg::*;
(
    input  logic   [STATE_W-1:0] state,
    input  logic                 in,
    output logic   [STATE_W-1:0] next_state
);

    always_comb begin
        next_state = S0;
        case (state)
            S0:      next_state = step_sel(in, S0,  S1);
            S1:      next_state = step_sel(in, S1,  S2);
            S2:      next_state = step_sel(in, S2,  S3);
            S3:      next_state = step_sel(in, S3,  S4);
            S4:      next_state = step_sel(in, S4,  S5);
            S5:      next_state = step_sel(in, S5,  S6);
            S6:      next_state = step_sel(in, S6,  S7);
            S7:      next_state = step_sel(in, S7,  S8);
            S8:      next_state = step_sel(in, S8,  S9);
            S9:      next_state = step_sel(in, S9,  S10);
            S10:     next_state = step_sel(in, S10, S11);
            S11:     next_state = step_sel(in, S11, S12);
            S12:     next_state = step_sel(in, S12, S13);
            S13:     next_state = step_sel(in, S13, S14);
            S14:     next_state = step_sel(in, S14, S15);
            S15:     next_state = step_sel(in, S15, S0);
            // Unknown encodings recover to S0.
            default: next_state = S0;
        endcase
    end

endmodule

// File: rtl/four_bit_counter.sv
// 4-bit up-counter as a 16-state Moore FSM; count is the registered state.
`timescale 1ns/1ps
module four_bit_counter
    import four_bit_counter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    output logic [STATE_W-1:0] count
);

    state_t state_q;
    state_t state_d;

    four_bit_counter_next u_next (
        .state      (state_q),
        .in         (in),
        .next_state (state_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign count = state_q;

endmodule

// File: tb/tb_four_bit_counter.sv
// Self-checking bench for four_bit_counter: vector table, directed corners, random run.
`timescale 1ns/1ps
module tb_four_bit_counter;

    logic       clk;
    logic       reset;
    logic       in;
    logic [3:0] count;

    int checks;
    int errors;
    int model;

    typedef struct {
        logic       in_v;
        logic [3:0] exp;
    } vec_t;

    four_bit_counter dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .count (count)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: count=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Drive in just after a falling edge, let one rising edge pass, then update model and check.
    task automatic step(input string name, input logic in_v);
        in = in_v;
        @(negedge clk);
        if (in_v === 1'b1) model = (model + 1) % 16;
        check(name, count, 4'(model));
    endtask

    // Reset low between edges must clear without a clock edge.
    task automatic async_reset(input string name);
        reset = 1'b0;
        #0.5;
        model = 0;
        check(name, count, 4'd0);
        @(negedge clk);
        check({name, "_held"}, count, 4'd0);
        reset = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        checks = 0;
        errors = 0;
        model  = 0;
        reset  = 1'b0;
        in     = 1'b1;

        // Power-up: 100 units of reset with clock running.
        repeat (50) begin
            @(negedge clk);
            check("powerup_reset", count, 4'd0);
        end

        // 16 enabled edges wrap back to 0.
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) step("wrap16", 1'b1);
        check("wrap16_final", count, 4'd0);

        // 50 edges from reset -> 50 mod 16 = 2, then clear between edges.
        async_reset("pre50_reset");
        repeat (50) step("run50", 1'b1);
        check("run50_final", count, 4'd2);
        async_reset("mid_count_reset");

        // Table of {in, expected count} starting from 0.
        vecs = '{
            '{1'b1, 4'd1}, '{1'b1, 4'd2}, '{1'b1, 4'd3}, '{1'b1, 4'd4}, '{1'b1, 4'd5},
            '{1'b0, 4'd5}, '{1'b0, 4'd5}, '{1'b0, 4'd5}, '{1'b0, 4'd5}, '{1'b0, 4'd5},
            '{1'b0, 4'd5}, '{1'b0, 4'd5}, '{1'b0, 4'd5}, '{1'b0, 4'd5}, '{1'b0, 4'd5},
            '{1'b1, 4'd6}, '{1'b0, 4'd6}, '{1'b1, 4'd7}, '{1'b1, 4'd8}, '{1'b1, 4'd9}
        };
        foreach (vecs[i]) begin
            in = vecs[i].in_v;
            @(negedge clk);
            check("vector", count, vecs[i].exp);
        end
        model = 9;

        // Unknown enable at count 9 holds and never produces X.
        repeat (3) begin
            in = 1'bx;
            @(negedge clk);
            check("x_enable_hold", count, 4'd9);
            checks++;
            if ((^count) === 1'bx) begin
                errors++;
                $display("FAIL x_on_count: count=%b expected=known", count);
            end
        end
        step("after_x_resume", 1'b1);
        check("after_x_value", count, 4'd10);

        // Toggle reset every 100 units over 500 units, starting low.
        in = 1'b1;
        for (int w = 0; w < 5; w++) begin
            reset = (w % 2 == 1) ? 1'b1 : 1'b0;
            model = 0;
            repeat (50) begin
                if (reset == 1'b0) begin
                    @(negedge clk);
                    check("periodic_low", count, 4'd0);
                end else begin
                    step("periodic_high", 1'b1);
                end
            end
        end

        // Random enable with occasional mid-run resets.
        reset = 1'b1;
        model = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                async_reset("rand_reset");
            end else begin
                step("rand_step", 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
